// File: rtl/uart_pkt_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_pkt_pkg                                                 |
// | Description : Shared state encoding, default constants and width helper    |
// |               for the UART receive packet controller.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package uart_pkt_pkg;

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        CMD     = 3'd1,
        LEN     = 3'd2,
        PAYLOAD = 3'd3,
        CSUM    = 3'd4,
        HOLD    = 3'd5
    } state_t;

    localparam logic [7:0] DEF_SYNC_BYTE     = 8'hA5;
    localparam int         DEF_MAX_LEN       = 8;
    localparam int         DEF_TIMEOUT_TICKS = 320;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int len_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage : uart_pkt_pkg
`default_nettype wire

// File: rtl/pkt_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pkt_timer                                                    |
// | Description : Inter-byte tick counter with clear/enable and expiry flag.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pkt_timer #(
    parameter  int TIMEOUT_TICKS = 320,
    localparam int c_cnt_w       = $clog2(TIMEOUT_TICKS + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    input  logic i_tick,
    output logic o_expire
);

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear || !i_enable) begin
            r_count <= '0;
        end else if (i_tick && !o_expire) begin
            r_count <= r_count + c_cnt_w'(1);
        end
    end

    assign o_expire = i_enable && (r_count == c_cnt_w'(TIMEOUT_TICKS));

endmodule : pkt_timer
`default_nettype wire

// File: rtl/uart_rx_pkt_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_rx_pkt_ctrl                                             |
// | Description : Frames UART RX bytes (SYNC,CMD,LEN,payload,CSUM) into        |
// |               validated command packets with a valid/ready handshake.      |
// |               Define UART_PKT_TIMEOUT_EN to enable the inter-byte timeout. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_rx_pkt_ctrl
    import uart_pkt_pkg::*;
#(
    parameter  int         MAX_LEN       = DEF_MAX_LEN,
    parameter  logic [7:0] SYNC_BYTE     = DEF_SYNC_BYTE,
    parameter  int         TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
    localparam int         c_len_w       = len_width(MAX_LEN + 1),
    localparam int         c_addr_w      = len_width(MAX_LEN)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx_done,
    input  logic [7:0]          rx_data,
    input  logic                tick,
    output logic                cmd_valid,
    input  logic                cmd_ready,
    output logic [7:0]          cmd_code,
    output logic [c_len_w-1:0]  cmd_len,
    input  logic [c_addr_w-1:0] rd_addr,
    output logic [7:0]          rd_data,
    output logic                err_csum,
    output logic                err_len,
    output logic                err_timeout,
    output logic                err_overrun,
    output logic                busy
);

    state_t             r_state;
    state_t             w_next_state;
    logic               r_rx_done_q;
    logic [7:0]         r_cmd_code;
    logic [7:0]         r_sum;
    logic [c_len_w-1:0] r_cmd_len;
    logic [c_len_w-1:0] r_idx;
    logic [7:0]         r_buf [MAX_LEN];
    logic               r_err_csum;
    logic               r_err_len;
    logic               r_err_overrun;

    logic               w_strb;
    logic [7:0]         w_sum_next;
    logic               w_len_bad;
    logic               w_csum_ok;
    logic               w_last_pl;
    logic               w_in_frame;
    logic               w_expire;
    logic               w_timeout;

    assign w_strb     = rx_done & ~r_rx_done_q;
    assign w_sum_next = r_sum + rx_data;
    assign w_len_bad  = (rx_data > 8'(MAX_LEN));
    assign w_csum_ok  = (w_sum_next == 8'h00);
    assign w_last_pl  = ((r_idx + c_len_w'(1)) == r_cmd_len);
    assign w_in_frame = (r_state == CMD) || (r_state == LEN) ||
                        (r_state == PAYLOAD) || (r_state == CSUM);
    // A strobe in the expiry cycle wins: the byte is taken, not the timeout.
    assign w_timeout  = w_in_frame & ~w_strb & w_expire;

`ifdef UART_PKT_TIMEOUT_EN
    logic r_err_timeout;

    pkt_timer #(
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) u_pkt_timer (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_strb),
        .i_enable (w_in_frame),
        .i_tick   (tick),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_err_timeout <= 1'b0;
        else        r_err_timeout <= w_timeout;
    end

    assign err_timeout = r_err_timeout;
`else
    localparam int c_unused_timeout = TIMEOUT_TICKS;
    logic w_unused_tick;

    assign w_unused_tick = tick;
    assign w_expire      = 1'b0;
    assign err_timeout   = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= HUNT;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            HUNT:    if (w_strb && rx_data == SYNC_BYTE) w_next_state = CMD;
            CMD:     if (w_strb) w_next_state = LEN;
            LEN: begin
                if (w_strb) begin
                    if (w_len_bad)             w_next_state = HUNT;
                    else if (rx_data == 8'h00) w_next_state = CSUM;
                    else                       w_next_state = PAYLOAD;
                end
            end
            PAYLOAD: if (w_strb && w_last_pl) w_next_state = CSUM;
            CSUM:    if (w_strb) w_next_state = w_csum_ok ? HOLD : HUNT;
            HOLD: begin
                // Handshake frees the slot; a same-cycle byte is judged as a HUNT byte.
                if (cmd_ready)
                    w_next_state = (w_strb && rx_data == SYNC_BYTE) ? CMD : HUNT;
            end
            default: w_next_state = HUNT;
        endcase
        if (w_timeout) w_next_state = HUNT;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_done_q   <= 1'b0;
            r_cmd_code    <= 8'h00;
            r_cmd_len     <= '0;
            r_idx         <= '0;
            r_sum         <= 8'h00;
            r_err_csum    <= 1'b0;
            r_err_len     <= 1'b0;
            r_err_overrun <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) r_buf[i] <= 8'h00;
        end else begin
            r_rx_done_q   <= rx_done;
            r_err_csum    <= w_strb && (r_state == CSUM) && !w_csum_ok;
            r_err_len     <= w_strb && (r_state == LEN) && w_len_bad;
            r_err_overrun <= w_strb && (r_state == HOLD) && !cmd_ready;
            if (w_strb) begin
                case (r_state)
                    HUNT: r_sum <= 8'h00;
                    CMD: begin
                        r_cmd_code <= rx_data;
                        r_sum      <= rx_data;
                    end
                    LEN: begin
                        if (!w_len_bad) begin
                            r_cmd_len <= rx_data[c_len_w-1:0];
                            r_sum     <= w_sum_next;
                            r_idx     <= '0;
                        end
                    end
                    PAYLOAD: begin
                        r_buf[r_idx[c_addr_w-1:0]] <= rx_data;
                        r_sum                      <= w_sum_next;
                        r_idx                      <= r_idx + c_len_w'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign cmd_valid   = (r_state == HOLD);
    assign busy        = (r_state != HUNT);
    assign cmd_code    = r_cmd_code;
    assign cmd_len     = r_cmd_len;
    assign rd_data     = (int'(rd_addr) < MAX_LEN) ? r_buf[rd_addr] : 8'h00;
    assign err_csum    = r_err_csum;
    assign err_len     = r_err_len;
    assign err_overrun = r_err_overrun;

endmodule : uart_rx_pkt_ctrl
`default_nettype wire

// File: doc/uart_rx_pkt_ctrl.md
Name: uart_rx_pkt_ctrl

Overview:
Controller that sequences the UART receive path (baud tick generator plus byte receiver) into framed command packets for game logic. It consumes the receiver's byte-done flag and data byte and hunts for a sync byte. It then collects CMD, LEN, payload and checksum, validates the frame, and presents it on a valid/ready handshake with a payload read port. It sits between the UART RX top and the game command decoder.

Parameters:
MAX_LEN, 8, maximum payload bytes per frame (1..16).
SYNC_BYTE, 8'hA5, frame start marker.
TIMEOUT_TICKS, 320, baud x16 ticks allowed between bytes inside a frame (two byte times at 16x oversampling).

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
rx_done  input  1  receiver byte-done flag (level; rising edge marks a new byte)
rx_data  input  8  received byte, stable while rx_done high
tick  input  1  baud x16 tick from the baud generator, one-cycle pulse
cmd_valid  output  1  validated frame available
cmd_ready  input  1  consumer accepts frame
cmd_code  output  8  CMD byte of held frame
cmd_len  output  clog2(MAX_LEN+1)  payload length of held frame
rd_addr  input  clog2(MAX_LEN)  payload read address
rd_data  output  8  payload byte at rd_addr (combinational)
err_csum  output  1  one-cycle pulse: checksum mismatch
err_len  output  1  one-cycle pulse: LEN > MAX_LEN
err_timeout  output  1  one-cycle pulse: inter-byte timeout
err_overrun  output  1  one-cycle pulse: byte arrived while frame held
busy  output  1  high in any state other than HUNT

Behaviour:
- Reset (reset low, async): state HUNT; cmd_valid, busy and all err_* = 0; cmd_code = 0, cmd_len = 0; payload buffer cleared to 0; edge register = 0; checksum and timer = 0.
- Byte strobe: strb = rx_done & ~rx_done_q; rx_done_q is registered every cycle. One byte per rising edge; a held-high rx_done never re-triggers.
- States, all transitions on strb unless noted:
  - HUNT: rx_data == SYNC_BYTE -> CMD with sum cleared; other bytes are ignored silently.
  - CMD: latch cmd_code, sum = rx_data -> LEN.
  - LEN: if rx_data > MAX_LEN -> pulse err_len, go to HUNT. Otherwise latch cmd_len and add to sum; go to PAYLOAD if LEN > 0, else CSUM.
  - PAYLOAD: write buf[idx]; add to sum; idx increments; after byte LEN-1 -> CSUM.
  - CSUM: if (sum + rx_data) mod 256 == 0 -> HOLD with cmd_valid = 1 on the next cycle. Otherwise pulse err_csum and go to HUNT.
  - HOLD: cmd_valid = 1; cmd_code, cmd_len and buffer are frozen. cmd_valid & cmd_ready -> HUNT, with cmd_valid low on the next cycle.
- Checksum arithmetic: 8-bit wrap-around sum of CMD, LEN, payload and CSUM must equal 0.
- HOLD overrun: strb without handshake -> byte dropped, err_overrun pulses.
- HOLD, strb in the same cycle as the handshake: the handshake completes and the byte is evaluated as a HUNT byte; a SYNC_BYTE moves to CMD; no overrun.
- Latency: cmd_valid rises the cycle after the CSUM strobe cycle. Error pulses assert the cycle after the offending strobe, for exactly 1 cycle.
- rd_data = buf[rd_addr] in any state. rd_addr >= MAX_LEN returns 8'h00. Content is guaranteed only in HOLD and only for addresses < cmd_len.
- No new frame overwrites the buffer while in HOLD.

Optional Feature:
Macro: UART_PKT_TIMEOUT_EN.
- Defined: in CMD, LEN, PAYLOAD and CSUM, count tick pulses; strb clears the count. When count reaches TIMEOUT_TICKS -> pulse err_timeout, go to HUNT. If strb and expiry fall in the same cycle, the strobe wins: byte processed, count cleared. The timer is idle and cleared in HUNT and HOLD.
- Undefined: no counter; err_timeout tied 0; tick unused; a partial frame waits indefinitely.

Decomposition:
- Package uart_pkt_pkg: state enum (HUNT, CMD, LEN, PAYLOAD, CSUM, HOLD), default SYNC_BYTE, MAX_LEN and TIMEOUT_TICKS constants, and a width helper for len/addr.
- Sub-module pkt_timer: tick counter with clear, enable and expire output; instantiated only under UART_PKT_TIMEOUT_EN.

Test Plan:
- Good frame: bytes A5,10,02,01,02,EB -> cmd_valid=1, cmd_code=10, cmd_len=2, rd_data[0]=01, rd_data[1]=02; cmd_ready=1 -> cmd_valid=0, busy=0.
- Zero-length frame: A5,20,00,E0 -> cmd_valid with cmd_len=0. Bad checksum: A5,10,02,01,02,EC -> err_csum 1-cycle pulse, no cmd_valid, state HUNT.
- Length error and resync: A5,30,09 (MAX_LEN=8) -> err_len pulse. Then immediate A5,30,00,D0 -> accepted frame. Garbage 00,FF,A4 before A5 is ignored.
- Hold/overrun: good frame with cmd_ready=0, then byte 55 -> err_overrun, frame data unchanged. A5 with cmd_ready=1 in the same cycle -> busy stays 1 (CMD), no overrun.
- rx_done held high 50 cycles with rx_data=A5 -> a single strobe only. Reset low mid-PAYLOAD -> all outputs 0, state HUNT immediately (async).
- With UART_PKT_TIMEOUT_EN: A5,10 then 320 ticks with no byte -> err_timeout, HUNT. A byte arriving at tick 319 -> no timeout. Without the macro, err_timeout is never asserted.
